// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the ID stage: opcodes, ALUOp encodings, control-field bit positions.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // wb_ctlout = {RegWrite, MemtoReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    // m_ctlout = {Branch, MemRead, MemWrite}
    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;
    // ex_ctlout = {RegDst, ALUOp[1:0], ALUSrc}
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    typedef struct packed {
        logic [1:0] wb;
        logic [2:0] m;
        logic [3:0] ex;
    } ctl_t;

    // Main control table; unknown opcodes decode to a NOP (all zero).
    function automatic ctl_t decode_ctl(input logic [5:0] op);
        ctl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.ex[EX_REGDST]                = 1'b1;
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_RTYPE;
                c.wb[WB_REGWRITE]              = 1'b1;
            end
            OP_LW: begin
                c.ex[EX_ALUSRC]                = 1'b1;
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
                c.wb[WB_MEMTOREG]              = 1'b1;
                c.wb[WB_REGWRITE]              = 1'b1;
                c.m[M_MEMREAD]                 = 1'b1;
            end
            OP_SW: begin
                c.ex[EX_ALUSRC]                = 1'b1;
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
                c.m[M_MEMWRITE]                = 1'b1;
            end
            OP_BEQ: begin
                c.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_SUB;
                c.m[M_BRANCH]                  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Opcodes whose rt field is a source operand (lw only writes rt).
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF/ID-in, WB-in and ID/EX-out signal bundle for the decode stage.
// Latency: n/a (wiring only).
// Backpressure: stall_out travels upstream through this bundle.
interface id_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [31:0]       instr_in;
    logic [DATA_W-1:0] npc_in;
    logic              valid_in;
    logic              flush_in;
    logic              wb_en;
    logic [REG_AW-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              stall_out;
    logic              valid_out;
    logic [1:0]        wb_ctlout;
    logic [2:0]        m_ctlout;
    logic [3:0]        ex_ctlout;
    logic [DATA_W-1:0] npcout;
    logic [DATA_W-1:0] rdata1out;
    logic [DATA_W-1:0] rdata2out;
    logic [DATA_W-1:0] s_extendout;
    logic [4:0]        rt_out;
    logic [4:0]        rd_out;

    modport master (
        output instr_in, npc_in, valid_in, flush_in, wb_en, wb_reg, wb_data,
        input  stall_out, valid_out, wb_ctlout, m_ctlout, ex_ctlout,
               npcout, rdata1out, rdata2out, s_extendout, rt_out, rd_out
    );

    modport slave (
        input  instr_in, npc_in, valid_in, flush_in, wb_en, wb_reg, wb_data,
        output stall_out, valid_out, wb_ctlout, m_ctlout, ex_ctlout,
               npcout, rdata1out, rdata2out, s_extendout, rt_out, rd_out
    );
endinterface

// File: rtl/id_stage_pipe_regfile.sv
// Two-read / one-write register file, r0 hard-wired to zero, optional write-through bypass.
// Latency: reads combinational, writes land on the rising edge.
// Backpressure: none; the write port is always accepted.
module id_regfile #(
    parameter int DATA_W    = 32,
    parameter int NREGS     = 32,
    parameter int BYPASS_EN = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);
    logic [DATA_W-1:0] mem [NREGS];

    // Storage: cleared on reset, r0 never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: r0 reads zero; a same-cycle write to a nonzero index wins when bypass is on.
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];
        if ((BYPASS_EN != 0) && we && (raddr1 != '0) && (waddr == raddr1)) rdata1 = wdata;
        if ((BYPASS_EN != 0) && we && (raddr2 != '0) && (waddr == raddr2)) rdata2 = wdata;
    end
endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: control decode, regfile read, sign extend, load-use hazard and the ID/EX register.
// Latency: 1 cycle instr_in -> ID/EX outputs (2 when a load-use stall inserts a bubble).
// Backpressure: stall_out (combinational) holds PC and IF/ID while a bubble is inserted.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NREGS     = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic         clk,
    input  logic         reset,
    id_stage_pipe_if.slave bus
);
    localparam int REG_AW = $clog2(NREGS);

    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    ctl_t              ctl;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] s_extend;
    logic              stall;

    assign opcode   = bus.instr_in[31:26];
    assign rs       = bus.instr_in[25:21];
    assign rt       = bus.instr_in[20:16];
    assign ctl      = decode_ctl(opcode);
    assign s_extend = {{(DATA_W-16){bus.instr_in[15]}}, bus.instr_in[15:0]};

    id_regfile #(
        .DATA_W    (DATA_W),
        .NREGS     (NREGS),
        .BYPASS_EN (BYPASS_EN)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (bus.wb_en),
        .waddr  (bus.wb_reg),
        .wdata  (bus.wb_data),
        .raddr1 (rs[REG_AW-1:0]),
        .raddr2 (rt[REG_AW-1:0]),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    // Load-use hazard: the load in ID/EX targets a register this instruction sources.
    always_comb begin
        stall = reset && bus.valid_in && bus.valid_out
              && bus.m_ctlout[M_MEMREAD] && (bus.rt_out != 5'd0)
              && ((bus.rt_out == rs) || ((bus.rt_out == rt) && reads_rt(opcode)));
    end

    assign bus.stall_out = stall;

    // ID/EX register: data always loads; flush, stall or an empty slot turn the control into a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.valid_out   <= 1'b0;
            bus.wb_ctlout   <= '0;
            bus.m_ctlout    <= '0;
            bus.ex_ctlout   <= '0;
            bus.npcout      <= '0;
            bus.rdata1out   <= '0;
            bus.rdata2out   <= '0;
            bus.s_extendout <= '0;
            bus.rt_out      <= '0;
            bus.rd_out      <= '0;
        end else begin
            bus.npcout      <= bus.npc_in;
            bus.rdata1out   <= rdata1;
            bus.rdata2out   <= rdata2;
            bus.s_extendout <= s_extend;
            bus.rt_out      <= bus.instr_in[20:16];
            bus.rd_out      <= bus.instr_in[15:11];
            if (bus.flush_in || stall || !bus.valid_in) begin
                bus.valid_out <= 1'b0;
                bus.wb_ctlout <= '0;
                bus.m_ctlout  <= '0;
                bus.ex_ctlout <= '0;
            end else begin
                bus.valid_out <= 1'b1;
                bus.wb_ctlout <= ctl.wb;
                bus.m_ctlout  <= ctl.m;
                bus.ex_ctlout <= ctl.ex;
            end
        end
    end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised successor to the single-issue decode stage.
- Decodes the instruction and reads the register file with write-through bypass.
- Sign-extends the immediate and detects load-use hazards.
- Owns the ID/EX pipeline register, with stall-bubble insertion and branch flush.
- Sits between the IF/ID latch and the EX stage; the WB stage drives the write-back port.

Parameters:
- DATA_W, 32, datapath width (≥16).
- NREGS, 32, register count (power of 2, ≤32); REG_AW = $clog2(NREGS).
- BYPASS_EN, 1, 1 = same-cycle write-back data forwarded to read ports.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- instr_in  in  32  instruction from IF/ID.
- npc_in  in  DATA_W  PC+4 from IF/ID.
- valid_in  in  1  IF/ID holds a real instruction.
- flush_in  in  1  branch taken; squash the instruction entering ID/EX.
- wb_en  in  1  register write enable from WB.
- wb_reg  in  REG_AW  write-back register index.
- wb_data  in  DATA_W  write-back data.
- stall_out  out  1  hold PC and IF/ID this cycle (combinational).
- valid_out  out  1  ID/EX holds a real instruction.
- wb_ctlout  out  2  {RegWrite, MemtoReg}.
- m_ctlout  out  3  {Branch, MemRead, MemWrite}.
- ex_ctlout  out  4  {RegDst, ALUOp[1:0], ALUSrc}.
- npcout  out  DATA_W  registered npc.
- rdata1out  out  DATA_W  registered rs value.
- rdata2out  out  DATA_W  registered rt value.
- s_extendout  out  DATA_W  registered sign-extended instr[15:0].
- rt_out  out  5  registered instr[20:16].
- rd_out  out  5  registered instr[15:11].

Behaviour:
- Reset (reset=0, async):
  - All registers cleared to 0.
  - All ID/EX outputs cleared to 0, valid_out=0.
  - stall_out is 0 while reset is asserted.
- Control decode (combinational). Columns are RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp:
  - 6'h00 R-type: 1,0,0,1,0,0,0,2'b10.
  - 6'h23 lw: 0,1,1,1,1,0,0,2'b00.
  - 6'h2B sw: 0,1,0,0,0,1,0,2'b00.
  - 6'h04 beq: 0,0,0,0,0,0,1,2'b01.
  - Any other opcode: all 0 (NOP).
- Register index truncation: rs = instr[25:21] and rt = instr[20:16], truncated to REG_AW bits for the read index.
- Register file:
  - Write on rising edge when wb_en=1 and wb_reg≠0.
  - Register 0 always reads 0; writes to it are ignored.
  - Read is combinational.
  - If BYPASS_EN=1, wb_en=1 and wb_reg equals a nonzero read index, that port returns wb_data in the same cycle.
- Sign extend: {{(DATA_W-16){instr[15]}}, instr[15:0]}.
- Hazard: stall_out=1 only when all of these hold:
  - valid_in=1 and valid_out=1.
  - m_ctlout[1] (ID/EX MemRead) = 1.
  - rt_out≠0.
  - rt_out equals rs, or rt_out equals rt and the decoded opcode is R-type, sw or beq.
- ID/EX update, every rising edge, priority order:
  1. flush_in=1: bubble. All three control fields = 0, valid_out=0; data fields are don't-care and are loaded normally.
  2. Else stall_out=1: bubble, same as above. The upstream IF/ID latch holds, so the instruction re-presents next cycle.
  3. Else valid_in=0: bubble.
  4. Else: load all decode results, valid_out=1.
- Latency: 1 cycle from instr_in to ID/EX outputs; 2 cycles when stalled.
- Simultaneous flush and stall: flush wins and stall_out still asserts. The squashed instruction is discarded upstream by IF flush logic.
- Reset during a stall: the bubble is discarded, everything is cleared, and stall_out drops immediately.
- Write-back and read of the same register in the same cycle:
  - BYPASS_EN=1: the new value is read.
  - BYPASS_EN=0: the old value is read.

Decomposition:
- Package id_pkg holds:
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ.
  - ALUOp encodings.
  - Bit-index constants for the fields of wb_ctlout, m_ctlout and ex_ctlout.
- Sub-module id_regfile: parametrised DATA_W/NREGS, async active-low clear, two read ports, one write port, optional bypass.
- Control decode, sign extend, hazard logic and the ID/EX register stay in the top.

Test Plan:
- Reset then R-type:
  - Stimulus: assert reset=0 for 2 cycles, release; write r8=5 and r9=7 via WB; present add $10,$8,$9 (0x01095020) with valid_in=1.
  - Response: next edge gives rdata1out=5, rdata2out=7, rd_out=10, ex_ctlout=4'b1100, wb_ctlout=2'b10, m_ctlout=0, valid_out=1.
- Load-use stall:
  - Stimulus: present lw $8,4($9) (0x8D280004), then add $10,$8,$9.
  - Response: stall_out=1 for exactly one cycle; a bubble appears (valid_out=0, control fields 0); the add issues the following cycle.
- Flush:
  - Stimulus: flush_in=1 with a valid sw presented.
  - Response: after the edge, valid_out=0 and m_ctlout=0.
- Bypass:
  - Stimulus: wb_en=1, wb_reg=8, wb_data=0xDEADBEEF in the same cycle an instruction reads r8.
  - Response: rdata1out=0xDEADBEEF with BYPASS_EN=1; the previous value with BYPASS_EN=0.
- Zero register:
  - Stimulus: write r0=0x1234.
  - Response: a later read of r0 returns 0; lw $0 followed by a use of $0 gives no stall.
- Sign extend:
  - Stimulus: immediate 0x8001 with DATA_W=32.
  - Response: s_extendout=0xFFFF8001; immediate 0x7FFF gives 0x00007FFF.
